// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared types and helpers for the highway / country-road phase scheduler.
package traffic_pkg;

   typedef enum logic [1:0] {
      RED    = 2'b00,
      YELLOW = 2'b01,
      GREEN  = 2'b10
   } light_t;

   typedef enum logic [2:0] {
      HG   = 3'd0,
      HY   = 3'd1,
      AR1  = 3'd2,
      CG   = 3'd3,
      CY   = 3'd4,
      AR2  = 3'd5,
      WALK = 3'd6
   } state_t;

   // Duration in cycles of the phase entered in state s.
   function automatic int unsigned phase_dur(input state_t s,
                                             input int unsigned min_hg,
                                             input int unsigned yel,
                                             input int unsigned allred,
                                             input int unsigned max_cg,
                                             input int unsigned walk_t);
      int unsigned d;
      case (s)
         HG:      d = min_hg;
         HY:      d = yel;
         AR1:     d = allred;
         CG:      d = max_cg;
         CY:      d = yel;
         AR2:     d = allred;
         WALK:    d = walk_t;
         default: d = min_hg;
      endcase
      return d;
   endfunction

   // Highway lamp colour shown in state s.
   function automatic light_t hwy_light(input state_t s);
      light_t l;
      case (s)
         HG:      l = GREEN;
         HY:      l = YELLOW;
         default: l = RED;
      endcase
      return l;
   endfunction

   // Country-road lamp colour shown in state s.
   function automatic light_t cntry_light(input state_t s);
      light_t l;
      case (s)
         CG:      l = GREEN;
         CY:      l = YELLOW;
         default: l = RED;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Down-counting phase timer: loads on phase entry, saturates at zero.
module phase_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: reload on request, otherwise count down and hold at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != {CNT_W{1'b0}}) begin
         count_d = count_q - CNT_W'(1'b1);
      end else begin
         count_d = {CNT_W{1'b0}};
      end
   end

   // Count register; the owner forces a load while its reset is asserted.
   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign expired = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Intersection phase scheduler: highway green by default, services latched
// country-road car and pedestrian requests through yellow and all-red.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned MIN_HG = 8,
   parameter int unsigned YEL    = 3,
   parameter int unsigned ALLRED = 1,
   parameter int unsigned MAX_CG = 6,
   parameter int unsigned WALK_T = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       car_sensor,
   input  logic       ped_req,
   output logic [1:0] hwy_signal,
   output logic [1:0] cntry_road_signal,
   output logic       walk,
   output logic       ped_pending,
   output logic [2:0] state_out,
   output logic [2:0] next_state_out
);

   state_t           state_q, state_d;
   logic             car_pending_q, car_pending_d;
   logic             ped_pending_q, ped_pending_d;
   light_t           hwy_q, hwy_d;
   light_t           cntry_q, cntry_d;
   logic             walk_q, walk_d;
   logic             expired_s;
   logic             load_s;
   state_t           dur_state_s;
   logic [CNT_W-1:0] load_val_s;

   // Phase transitions; unused encodings fall back to highway green.
   always_comb begin
      state_d = state_q;
      case (state_q)
         HG: begin
            if (expired_s && (car_pending_q || ped_pending_q)) state_d = HY;
            else                                               state_d = HG;
         end
         HY: begin
            if (expired_s) state_d = AR1;
            else           state_d = HY;
         end
         AR1: begin
            if (!expired_s)         state_d = AR1;
            else if (car_pending_q) state_d = CG;
            else if (ped_pending_q) state_d = WALK;
            else                    state_d = HG;
         end
         CG: begin
            if (expired_s || !car_sensor) state_d = CY;
            else                          state_d = CG;
         end
         CY: begin
            if (expired_s) state_d = AR2;
            else           state_d = CY;
         end
         AR2: begin
            if (!expired_s)         state_d = AR2;
            else if (ped_pending_q) state_d = WALK;
            else                    state_d = HG;
         end
         WALK: begin
            if (expired_s) state_d = HG;
            else           state_d = WALK;
         end
         default: state_d = HG;
      endcase
   end

   // Request latches: clearing on entry to the serving phase wins over a new request.
   always_comb begin
      car_pending_d = car_pending_q;
      ped_pending_d = ped_pending_q;
      if ((state_d == CG) && (state_q != CG)) begin
         car_pending_d = 1'b0;
      end else if (car_sensor && (state_q != CG)) begin
         car_pending_d = 1'b1;
      end else begin
         car_pending_d = car_pending_q;
      end
      if ((state_d == WALK) && (state_q != WALK)) begin
         ped_pending_d = 1'b0;
      end else if (ped_req && (state_q != WALK)) begin
         ped_pending_d = 1'b1;
      end else begin
         ped_pending_d = ped_pending_q;
      end
   end

   // Lamp decode of the upcoming state so the lamps are registered alongside it.
   always_comb begin
      hwy_d   = hwy_light(state_d);
      cntry_d = cntry_light(state_d);
      walk_d  = (state_d == WALK);
   end

   // Timer reload on every phase change, and to the highway-green length on reset.
   always_comb begin
      dur_state_s = state_d;
      if (!reset_n) begin
         dur_state_s = HG;
         load_s      = 1'b1;
      end else begin
         dur_state_s = state_d;
         load_s      = (state_d != state_q);
      end
      load_val_s = CNT_W'(phase_dur(dur_state_s, MIN_HG, YEL, ALLRED, MAX_CG, WALK_T) - 32'd1);
   end

   phase_timer #(
      .CNT_W (CNT_W)
   ) u_phase_timer (
      .clk      (clk),
      .load     (load_s),
      .load_val (load_val_s),
      .expired  (expired_s)
   );

   // State, request latches and lamp registers; reset goes straight to highway green.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= HG;
         car_pending_q <= 1'b0;
         ped_pending_q <= 1'b0;
         hwy_q         <= GREEN;
         cntry_q       <= RED;
         walk_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         car_pending_q <= car_pending_d;
         ped_pending_q <= ped_pending_d;
         hwy_q         <= hwy_d;
         cntry_q       <= cntry_d;
         walk_q        <= walk_d;
      end
   end

   assign hwy_signal        = hwy_q;
   assign cntry_road_signal = cntry_q;
   assign walk              = walk_q;
   assign ped_pending       = ped_pending_q;
   assign state_out         = state_q;
   assign next_state_out    = state_d;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed, table-driven bench for traffic_phase_scheduler (default parameters).
module tb_traffic_phase_scheduler;

   localparam logic [2:0] S_HG   = 3'd0;
   localparam logic [2:0] S_HY   = 3'd1;
   localparam logic [2:0] S_AR1  = 3'd2;
   localparam logic [2:0] S_CG   = 3'd3;
   localparam logic [2:0] S_CY   = 3'd4;
   localparam logic [2:0] S_AR2  = 3'd5;
   localparam logic [2:0] S_WALK = 3'd6;

   localparam logic [1:0] L_RED    = 2'b00;
   localparam logic [1:0] L_YELLOW = 2'b01;
   localparam logic [1:0] L_GREEN  = 2'b10;

   typedef struct {
      bit         start;   // apply a fresh reset before this vector (vector is cycle 0)
      bit         car;     // car_sensor driven during this cycle
      bit         ped;     // ped_req driven during this cycle
      bit         rstn;    // reset_n driven during this cycle
      logic [2:0] st;      // expected state_out in this cycle
      bit         pp;      // expected ped_pending in this cycle
   } vec_t;

   logic       clk;
   logic       reset_n;
   logic       car_sensor;
   logic       ped_req;
   logic [1:0] hwy_signal;
   logic [1:0] cntry_road_signal;
   logic       walk;
   logic       ped_pending;
   logic [2:0] state_out;
   logic [2:0] next_state_out;

   int   checks;
   int   errors;
   int   vidx;
   bit   start_next;
   vec_t vecs[$];

   traffic_phase_scheduler dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .car_sensor        (car_sensor),
      .ped_req           (ped_req),
      .hwy_signal        (hwy_signal),
      .cntry_road_signal (cntry_road_signal),
      .walk              (walk),
      .ped_pending       (ped_pending),
      .state_out         (state_out),
      .next_state_out    (next_state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] exp_hwy(input logic [2:0] st);
      if (st == S_HG)      return L_GREEN;
      else if (st == S_HY) return L_YELLOW;
      else                 return L_RED;
   endfunction

   function automatic logic [1:0] exp_cntry(input logic [2:0] st);
      if (st == S_CG)      return L_GREEN;
      else if (st == S_CY) return L_YELLOW;
      else                 return L_RED;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s (vector %0d, t=%0t): got %0h expected %0h", name, vidx, $time, act, exp);
      end
   endtask

   task automatic seg(input int n, input logic [2:0] st, input bit car, input bit ped, input bit pp);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.start = start_next;
         v.car   = car;
         v.ped   = ped;
         v.rstn  = 1'b1;
         v.st    = st;
         v.pp    = pp;
         vecs.push_back(v);
         start_next = 1'b0;
      end
   endtask

   task automatic do_reset();
      car_sensor = 1'b0;
      ped_req    = 1'b0;
      reset_n    = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t rv;
      checks     = 0;
      errors     = 0;
      vidx       = -1;
      start_next = 1'b0;
      reset_n    = 1'b0;
      car_sensor = 1'b0;
      ped_req    = 1'b0;

      // Idle: 30 cycles of highway green.
      start_next = 1'b1;
      seg(30, S_HG, 1'b0, 1'b0, 1'b0);

      // Car pulse in cycle 2; afterwards no stale car request keeps HG short.
      start_next = 1'b1;
      seg(2,  S_HG,  1'b0, 1'b0, 1'b0);
      seg(1,  S_HG,  1'b1, 1'b0, 1'b0);
      seg(5,  S_HG,  1'b0, 1'b0, 1'b0);
      seg(3,  S_HY,  1'b0, 1'b0, 1'b0);
      seg(1,  S_AR1, 1'b0, 1'b0, 1'b0);
      seg(1,  S_CG,  1'b0, 1'b0, 1'b0);
      seg(3,  S_CY,  1'b0, 1'b0, 1'b0);
      seg(1,  S_AR2, 1'b0, 1'b0, 1'b0);
      seg(11, S_HG,  1'b0, 1'b0, 1'b0);

      // Pedestrian at cycle 1; request during WALK is dropped.
      start_next = 1'b1;
      seg(1, S_HG,   1'b0, 1'b0, 1'b0);
      seg(1, S_HG,   1'b0, 1'b1, 1'b0);
      seg(6, S_HG,   1'b0, 1'b0, 1'b1);
      seg(3, S_HY,   1'b0, 1'b0, 1'b1);
      seg(1, S_AR1,  1'b0, 1'b0, 1'b1);
      seg(1, S_WALK, 1'b0, 1'b0, 1'b0);
      seg(1, S_WALK, 1'b0, 1'b1, 1'b0);
      seg(2, S_WALK, 1'b0, 1'b0, 1'b0);
      seg(4, S_HG,   1'b0, 1'b0, 1'b0);

      // Car and pedestrian together at cycle 3: car first, then walk via AR2.
      start_next = 1'b1;
      seg(3, S_HG,   1'b0, 1'b0, 1'b0);
      seg(1, S_HG,   1'b1, 1'b1, 1'b0);
      seg(4, S_HG,   1'b0, 1'b0, 1'b1);
      seg(3, S_HY,   1'b0, 1'b0, 1'b1);
      seg(1, S_AR1,  1'b0, 1'b0, 1'b1);
      seg(1, S_CG,   1'b0, 1'b0, 1'b1);
      seg(3, S_CY,   1'b0, 1'b0, 1'b1);
      seg(1, S_AR2,  1'b0, 1'b0, 1'b1);
      seg(1, S_WALK, 1'b0, 1'b0, 1'b0);
      seg(1, S_WALK, 1'b0, 1'b1, 1'b0);
      seg(2, S_WALK, 1'b0, 1'b0, 1'b0);
      seg(3, S_HG,   1'b0, 1'b0, 1'b0);

      // Car held: CG capped at 6 cycles, request re-latched, HG then only MIN_HG long.
      start_next = 1'b1;
      seg(8, S_HG,  1'b1, 1'b0, 1'b0);
      seg(3, S_HY,  1'b1, 1'b0, 1'b0);
      seg(1, S_AR1, 1'b1, 1'b0, 1'b0);
      seg(6, S_CG,  1'b1, 1'b0, 1'b0);
      seg(3, S_CY,  1'b1, 1'b0, 1'b0);
      seg(1, S_AR2, 1'b1, 1'b0, 1'b0);
      seg(8, S_HG,  1'b1, 1'b0, 1'b0);
      seg(2, S_HY,  1'b1, 1'b0, 1'b0);

      // Reset mid-CY with a pending pedestrian: back to HG, flags cleared, full HG.
      start_next = 1'b1;
      seg(2, S_HG,  1'b0, 1'b0, 1'b0);
      seg(1, S_HG,  1'b1, 1'b0, 1'b0);
      seg(5, S_HG,  1'b0, 1'b0, 1'b0);
      seg(3, S_HY,  1'b0, 1'b0, 1'b0);
      seg(1, S_AR1, 1'b0, 1'b0, 1'b0);
      seg(1, S_CG,  1'b0, 1'b0, 1'b0);
      seg(1, S_CY,  1'b0, 1'b1, 1'b0);
      rv.start = 1'b0; rv.car = 1'b0; rv.ped = 1'b1; rv.rstn = 1'b0;
      rv.st = S_CY; rv.pp = 1'b1;
      vecs.push_back(rv);
      seg(1, S_HG,  1'b1, 1'b0, 1'b0);
      seg(7, S_HG,  1'b0, 1'b0, 1'b0);
      seg(3, S_HY,  1'b0, 1'b0, 1'b0);
      seg(1, S_AR1, 1'b0, 1'b0, 1'b0);
      seg(1, S_CG,  1'b0, 1'b0, 1'b0);

      // Hand-written: reset values and next_state_out around the first HG expiry.
      do_reset();
      chk("reset_state", {5'd0, state_out}, {5'd0, S_HG});
      chk("reset_hwy", {6'd0, hwy_signal}, {6'd0, L_GREEN});
      chk("reset_cntry", {6'd0, cntry_road_signal}, {6'd0, L_RED});
      chk("reset_walk", {7'd0, walk}, 8'd0);
      chk("reset_ped_pending", {7'd0, ped_pending}, 8'd0);
      chk("reset_next_state", {5'd0, next_state_out}, {5'd0, S_HG});
      car_sensor = 1'b1;
      step();
      car_sensor = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("next_state_c6", {5'd0, next_state_out}, {5'd0, S_HG});
      step();
      chk("state_c7", {5'd0, state_out}, {5'd0, S_HG});
      chk("next_state_c7", {5'd0, next_state_out}, {5'd0, S_HY});
      step();
      chk("state_c8", {5'd0, state_out}, {5'd0, S_HY});

      // Table-driven vectors.
      for (int i = 0; i < vecs.size(); i++) begin
         vidx = i;
         if (vecs[i].start) do_reset();
         car_sensor = vecs[i].car;
         ped_req    = vecs[i].ped;
         reset_n    = vecs[i].rstn;
         #1;
         chk("state", {5'd0, state_out}, {5'd0, vecs[i].st});
         chk("hwy", {6'd0, hwy_signal}, {6'd0, exp_hwy(vecs[i].st)});
         chk("cntry", {6'd0, cntry_road_signal}, {6'd0, exp_cntry(vecs[i].st)});
         chk("walk", {7'd0, walk}, {7'd0, (vecs[i].st == S_WALK)});
         chk("ped_pending", {7'd0, ped_pending}, {7'd0, vecs[i].pp});
         if ((i + 1 < vecs.size()) && !vecs[i + 1].start && vecs[i].rstn) begin
            chk("next_state", {5'd0, next_state_out}, {5'd0, vecs[i + 1].st});
         end
         @(posedge clk);
         #1;
      end
      reset_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
